// File: rtl/fp16_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : fp16_accumulator
// Purpose  : Streaming FP16 group reducer. Sums a stream of FP16 product
//            words, grouped by a last marker, into one FP16 result presented
//            on a valid/ready port. IEEE half layout, denormals supported,
//            truncation toward zero, exponent 31 always means infinity.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_data[15:0]/in_last   - product stream
//            out_valid/out_ready/out_data[15:0]        - group sum
//            out_count[COUNT_W-1:0]                    - terms in group (sat.)
// Revision : 1.0 - initial release
// ============================================================================
module fp16_accumulator #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_data,
    output logic [COUNT_W-1:0] out_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    logic [1:0]         r_state;
    logic [15:0]        r_acc;
    logic [COUNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // Adder: acc (operand a) + in_data (operand b)
    // ------------------------------------------------------------------
    logic [4:0]  w_exp_a, w_exp_b, w_exp_l, w_exp_s, w_exp_diff;
    logic [13:0] w_mag_a, w_mag_b, w_mag_l, w_mag_s, w_mag_s_al;
    logic        w_a_big, w_sign_l;
    logic [14:0] w_sum;
    logic [3:0]  w_lz;
    logic [4:0]  w_lim, w_shl;
    logic [5:0]  w_norm_exp;
    logic [10:0] w_norm_keep;
    logic [4:0]  w_exp_field;
    logic [15:0] w_add_result;

    // Exponent 0 behaves as exponent 1 with no hidden bit; 3 guard bits.
    assign w_exp_a = (r_acc[14:10] == 5'd0) ? 5'd1 : r_acc[14:10];
    assign w_exp_b = (in_data[14:10] == 5'd0) ? 5'd1 : in_data[14:10];
    assign w_mag_a = {|r_acc[14:10], r_acc[9:0], 3'b000};
    assign w_mag_b = {|in_data[14:10], in_data[9:0], 3'b000};

    assign w_a_big  = (w_exp_a > w_exp_b) ||
                      ((w_exp_a == w_exp_b) && (w_mag_a >= w_mag_b));
    assign w_exp_l  = w_a_big ? w_exp_a : w_exp_b;
    assign w_exp_s  = w_a_big ? w_exp_b : w_exp_a;
    assign w_mag_l  = w_a_big ? w_mag_a : w_mag_b;
    assign w_mag_s  = w_a_big ? w_mag_b : w_mag_a;
    assign w_sign_l = w_a_big ? r_acc[15] : in_data[15];

    assign w_exp_diff = w_exp_l - w_exp_s;
    assign w_mag_s_al = (w_exp_diff >= 5'd14) ? 14'd0 : (w_mag_s >> w_exp_diff);

    // Larger operand is never smaller than the aligned one, so no underflow.
    assign w_sum = (r_acc[15] == in_data[15]) ?
                   ({1'b0, w_mag_l} + {1'b0, w_mag_s_al}) :
                   ({1'b0, w_mag_l} - {1'b0, w_mag_s_al});

    // Leading zeros of the 14-bit magnitude (14 only for a zero sum).
    always_comb begin
        w_lz = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (w_sum[i]) begin
                w_lz = 4'(13 - i);
            end
        end
    end

    // Left shift is capped so the exponent never goes below 1; whatever is
    // left without a hidden bit is a denormal.
    assign w_lim = w_exp_l - 5'd1;
    assign w_shl = ({1'b0, w_lz} < w_lim) ? {1'b0, w_lz} : w_lim;

    always_comb begin
        if (w_sum[14]) begin
            w_norm_keep = w_sum[14:4];
            w_norm_exp  = {1'b0, w_exp_l} + 6'd1;
        end else begin
            w_norm_keep = 11'((w_sum[13:0] << w_shl) >> 3);
            w_norm_exp  = {1'b0, w_exp_l} - {1'b0, w_shl};
        end
    end

    assign w_exp_field = w_norm_keep[10] ? w_norm_exp[4:0] : 5'd0;

    always_comb begin
        w_add_result = {w_sign_l, w_exp_field, w_norm_keep[9:0]};
        if (r_acc[14:10] == 5'h1F) begin
            w_add_result = {r_acc[15], 5'h1F, 10'h000};
        end else if (in_data[14:10] == 5'h1F) begin
            w_add_result = {in_data[15], 5'h1F, 10'h000};
        end else if (w_sum == 15'd0) begin
            w_add_result = 16'h0000;
        end else if (w_norm_exp >= 6'd31) begin
            w_add_result = {w_sign_l, 5'h1F, 10'h000};
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic w_accept, w_take;

    assign in_ready  = (r_state != c_HOLD);
    assign out_valid = (r_state == c_HOLD);
    assign w_accept  = in_valid & in_ready;
    assign w_take    = out_valid & out_ready;
    assign out_data  = r_acc;
    assign out_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_acc   <= 16'h0000;
            r_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= in_data;
                        r_count <= COUNT_W'(1);
                        r_state <= in_last ? c_HOLD : c_ACC;
                    end
                end
                c_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_add_result;
                        if (!(&r_count)) begin
                            r_count <= r_count + COUNT_W'(1);
                        end
                        if (in_last) begin
                            r_state <= c_HOLD;
                        end
                    end
                end
                c_HOLD: begin
                    if (w_take) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
